// File: rtl/bf_exec_ctrl.sv
// Brainfuck execution controller: fetch/decode, cell ALU sequencing, data pointer,
// bracket scanning and valid/ready byte I/O. One instruction or scan step per cycle.
module bf_exec_ctrl #(
    parameter int PC_W    = 12,
    parameter int DP_W    = 10,
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [7:0]         imem_data,
    output logic [DP_W-1:0]    dmem_addr,
    input  logic [7:0]         dmem_rdata,
    output logic [7:0]         dmem_wdata,
    output logic               dmem_we,
    output logic [7:0]         a,
    output logic               nochange,
    output logic               decrement,
    output logic               increment,
    input  logic [7:0]         out,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               busy,
    output logic               halted,
    output logic               error
);

    localparam logic [7:0] CH_INC   = 8'h2B;  // '+'
    localparam logic [7:0] CH_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] CH_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] CH_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] CH_OPEN  = 8'h5B;  // '['
    localparam logic [7:0] CH_CLOSE = 8'h5D;  // ']'
    localparam logic [7:0] CH_OUT   = 8'h2E;  // '.'
    localparam logic [7:0] CH_IN    = 8'h2C;  // ','
    localparam logic [7:0] CH_END   = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_SCAN_F, S_SCAN_B, S_OUT, S_IN, S_HALT
    } state_t;

    state_t               state_reg;
    logic [PC_W-1:0]      pc_reg;
    logic [DP_W-1:0]      dp_reg;
    logic [DEPTH_W-1:0]   depth_reg;
    logic [7:0]           out_data_reg;
    logic                 out_valid_reg;
    logic                 error_reg;

    logic cell_zero, pc_max, pc_min, depth_max;
    logic exec_inc, exec_dec;
    logic scan_open, scan_close, scan_done, scan_fwd, scan_move_fault;

    assign cell_zero = (dmem_rdata == 8'h00);
    assign pc_max    = &pc_reg;
    assign pc_min    = (pc_reg == '0);
    assign depth_max = &depth_reg;

    assign exec_inc  = (state_reg == S_EXEC) && (imem_data == CH_INC);
    assign exec_dec  = (state_reg == S_EXEC) && (imem_data == CH_DEC);

    // In a backward scan the roles of the brackets swap: ']' nests deeper, '[' closes.
    assign scan_open  = (state_reg == S_SCAN_F) ? (imem_data == CH_OPEN)  : (imem_data == CH_CLOSE);
    assign scan_close = (state_reg == S_SCAN_F) ? (imem_data == CH_CLOSE) : (imem_data == CH_OPEN);
    assign scan_done  = scan_close && (depth_reg == DEPTH_W'(1));
    assign scan_fwd   = (state_reg == S_SCAN_F) || scan_done;
    assign scan_move_fault = scan_fwd ? pc_max : pc_min;

    assign imem_addr  = pc_reg;
    assign dmem_addr  = dp_reg;
    assign a          = dmem_rdata;
    assign increment  = exec_inc;
    assign decrement  = exec_dec;
    assign nochange   = !(exec_inc || exec_dec);
    assign in_ready   = (state_reg == S_IN);
    assign dmem_we    = exec_inc || exec_dec || (in_ready && in_valid);
    assign dmem_wdata = in_ready ? in_data : out;
    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign halted     = (state_reg == S_HALT);
    assign error      = error_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            pc_reg        <= '0;
            dp_reg        <= '0;
            depth_reg     <= '0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_reg    <= '0;
                        dp_reg    <= '0;
                        depth_reg <= '0;
                        error_reg <= 1'b0;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (imem_data)
                        CH_END: state_reg <= S_HALT;
                        CH_OUT: begin
                            out_data_reg  <= dmem_rdata;
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_OUT;
                        end
                        CH_IN: state_reg <= S_IN;
                        CH_CLOSE: begin
                            if (cell_zero && pc_max) begin
                                error_reg <= 1'b1;
                                state_reg <= S_HALT;
                            end else if (cell_zero) begin
                                pc_reg <= pc_reg + 1'b1;
                            end else if (pc_min) begin
                                error_reg <= 1'b1;
                                state_reg <= S_HALT;
                            end else begin
                                depth_reg <= DEPTH_W'(1);
                                pc_reg    <= pc_reg - 1'b1;
                                state_reg <= S_SCAN_B;
                            end
                        end
                        default: begin
                            // '+', '-', '>', '<', '[' and comment bytes all advance pc.
                            if (imem_data == CH_RIGHT) dp_reg <= dp_reg + 1'b1;
                            if (imem_data == CH_LEFT)  dp_reg <= dp_reg - 1'b1;
                            if (pc_max) begin
                                error_reg <= 1'b1;
                                state_reg <= S_HALT;
                            end else begin
                                pc_reg <= pc_reg + 1'b1;
                                if (imem_data == CH_OPEN && cell_zero) begin
                                    depth_reg <= DEPTH_W'(1);
                                    state_reg <= S_SCAN_F;
                                end
                            end
                        end
                    endcase
                end
                S_SCAN_F, S_SCAN_B: begin
                    if (imem_data == CH_END || (scan_open && depth_max) || scan_move_fault) begin
                        error_reg <= 1'b1;
                        state_reg <= S_HALT;
                    end else begin
                        if (scan_open)  depth_reg <= depth_reg + 1'b1;
                        if (scan_close) depth_reg <= depth_reg - 1'b1;
                        pc_reg <= scan_fwd ? pc_reg + 1'b1 : pc_reg - 1'b1;
                        if (scan_done) state_reg <= S_EXEC;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (pc_max) begin
                            error_reg <= 1'b1;
                            state_reg <= S_HALT;
                        end else begin
                            pc_reg    <= pc_reg + 1'b1;
                            state_reg <= S_EXEC;
                        end
                    end
                end
                S_IN: begin
                    if (in_valid) begin
                        if (pc_max) begin
                            error_reg <= 1'b1;
                            state_reg <= S_HALT;
                        end else begin
                            pc_reg    <= pc_reg + 1'b1;
                            state_reg <= S_EXEC;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Bench for bf_exec_ctrl: directed programs plus random programs checked against a
// behavioural Brainfuck interpreter; output bytes are scoreboarded by a separate monitor.
module tb_bf_exec_ctrl;

    localparam int PC_W    = 12;
    localparam int DP_W    = 10;
    localparam int DEPTH_W = 8;
    localparam int NPROG   = 1 << PC_W;
    localparam int NCELL   = 1 << DP_W;

    logic            clk = 1'b0;
    logic            rst_n, start;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data;
    logic [DP_W-1:0] dmem_addr;
    logic [7:0]      dmem_rdata, dmem_wdata;
    logic            dmem_we;
    logic [7:0]      a, alu_out;
    logic            nochange, decrement, increment;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      in_data = 8'h00;
    logic            in_valid = 1'b0;
    logic            in_ready, busy, halted, error;

    always #5 clk = ~clk;

    bf_exec_ctrl #(.PC_W(PC_W), .DP_W(DP_W), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .a(a), .nochange(nochange), .decrement(decrement), .increment(increment), .out(alu_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .halted(halted), .error(error)
    );

    // Program ROM, data RAM and ALU around the controller.
    logic [7:0] imem [NPROG];
    logic [7:0] dmem [NCELL];
    logic       clr_mem = 1'b1;
    int         wr_count = 0;

    assign imem_data = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign alu_out = increment ? a + 8'd1 : (decrement ? a - 8'd1 : a);

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < NCELL; i++) dmem[i] <= 8'h00;
            wr_count <= 0;
        end else if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference interpreter
    localparam logic [7:0] C_INC = 8'h2B, C_DEC = 8'h2D, C_R = 8'h3E, C_L = 8'h3C;
    localparam logic [7:0] C_OPEN = 8'h5B, C_CLOSE = 8'h5D, C_OUT = 8'h2E, C_IN = 8'h2C;

    logic [7:0] ref_cell [NCELL];
    logic [7:0] ref_out [$];
    logic [7:0] ref_in [$];
    bit         ref_err;

    // Returns 1 if the program stops (halt or fault) within `limit` steps.
    function automatic bit ref_run(input int limit);
        int pc = 0, dp = 0, steps = 0, d, p, in_idx = 0;
        logic [7:0] c;
        ref_out.delete();
        ref_err = 1'b0;
        for (int i = 0; i < NCELL; i++) ref_cell[i] = 8'h00;
        while (1) begin
            steps++;
            if (steps > limit) return 1'b0;
            c = imem[pc];
            if (c == 8'h00) return 1'b1;
            case (c)
                C_INC: ref_cell[dp] = ref_cell[dp] + 8'd1;
                C_DEC: ref_cell[dp] = ref_cell[dp] - 8'd1;
                C_R:   dp = (dp + 1) % NCELL;
                C_L:   dp = (dp + NCELL - 1) % NCELL;
                C_OUT: ref_out.push_back(ref_cell[dp]);
                C_IN: begin
                    if (in_idx >= ref_in.size()) return 1'b0;
                    ref_cell[dp] = ref_in[in_idx];
                    in_idx++;
                end
                C_OPEN: if (ref_cell[dp] == 8'h00) begin
                    d = 1; p = pc;
                    while (d > 0) begin
                        steps++;
                        p++;
                        if (p >= NPROG || imem[p] == 8'h00) begin ref_err = 1'b1; return 1'b1; end
                        if (imem[p] == C_OPEN) begin
                            if (d == (1 << DEPTH_W) - 1) begin ref_err = 1'b1; return 1'b1; end
                            d++;
                        end else if (imem[p] == C_CLOSE) d--;
                    end
                    pc = p;
                end
                C_CLOSE: if (ref_cell[dp] != 8'h00) begin
                    d = 1; p = pc;
                    while (d > 0) begin
                        steps++;
                        if (p == 0) begin ref_err = 1'b1; return 1'b1; end
                        p--;
                        if (imem[p] == 8'h00) begin ref_err = 1'b1; return 1'b1; end
                        if (imem[p] == C_CLOSE) begin
                            if (d == (1 << DEPTH_W) - 1) begin ref_err = 1'b1; return 1'b1; end
                            d++;
                        end else if (imem[p] == C_OPEN) d--;
                    end
                    pc = p;
                end
                default: ;
            endcase
            if (pc == NPROG - 1) begin ref_err = 1'b1; return 1'b1; end
            pc++;
        end
        return 1'b1;
    endfunction

    // Stream driver: random out_ready / in_valid, input bytes from in_q.
    int         ready_pct = 100;
    int         in_pct = 100;
    logic [7:0] in_q [$];
    logic       drv_fire;

    always begin
        @(negedge clk);
        drv_fire = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (drv_fire && in_q.size() > 0) void'(in_q.pop_front());
        out_ready = ($urandom_range(99) < ready_pct);
        in_valid  = (in_q.size() > 0) && ($urandom_range(99) < in_pct);
        in_data   = (in_q.size() > 0) ? in_q[0] : 8'($urandom);
    end

    // Monitor: scoreboard output bytes, stream stability, one-hot ALU selects.
    logic [7:0] exp_q [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         onehot_bad = 0;
    int         out_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (!$onehot({nochange, decrement, increment})) onehot_bad++;
            if (prev_stall) begin
                check("out_valid_held", int'(out_valid), 1);
                check("out_data_stable", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                out_seen++;
                $display("out byte 0x%02h at %0t", out_data, $time);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_unexpected: got byte 0x%02h, expected no byte", out_data);
                end else begin
                    check("out_byte", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic load_str(input string s);
        for (int i = 0; i < 64; i++) imem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) imem[i] = s[i];
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_halted"}, int'(halted), 0);
        check({tag, "_error"}, int'(error), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_dmem_we"}, int'(dmem_we), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_alu_sel"}, int'({nochange, decrement, increment}), 3'b100);
        check({tag, "_imem_addr"}, int'(imem_addr), 0);
        check({tag, "_dmem_addr"}, int'(dmem_addr), 0);
    endtask

    // Runs the program currently in imem against the reference results in ref_*.
    task automatic run_current(input string name, input int budget);
        int n_mis = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        clr_mem = 1'b1;
        @(posedge clk); #1;
        clr_mem = 1'b0;
        exp_q.delete();
        foreach (ref_out[i]) exp_q.push_back(ref_out[i]);
        in_q.delete();
        foreach (ref_in[i]) in_q.push_back(ref_in[i]);
        onehot_bad = 0;
        out_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_busy_after_start"}, int'(busy), 1);
        check({name, "_error_after_start"}, int'(error), 0);
        for (int k = 0; k < budget; k++) begin
            if (halted) begin done = 1'b1; break; end
            @(negedge clk);
        end
        check({name, "_halted"}, int'(done), 1);
        check({name, "_error"}, int'(error), int'(ref_err));
        check({name, "_missing_out"}, exp_q.size(), 0);
        check({name, "_alu_onehot_bad"}, onehot_bad, 0);
        for (int i = 0; i < NCELL; i++) if (dmem[i] != ref_cell[i]) n_mis++;
        check({name, "_cells_differ"}, n_mis, 0);
        $display("run %s: outputs=%0d error=%0d writes=%0d", name, out_seen, error, wr_count);
        exp_q.delete();
    endtask

    task automatic directed(input string name, input string prog, input logic [7:0] inb);
        load_str(prog);
        ref_in.delete();
        ref_in.push_back(inb);
        void'(ref_run(5000));
        run_current(name, 5000);
    endtask

    task automatic gen_prog();
        string alph = "++--><[].,#";
        int len = $urandom_range(30, 6);
        for (int i = 0; i < 64; i++) imem[i] = 8'h00;
        for (int i = 0; i < len; i++) imem[i] = alph[$urandom_range(alph.len() - 1)];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NPROG; i++) imem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_mem = 1'b0;
        @(negedge clk);
        check_reset("reset");

        directed("inc3", "+++.", 8'h00);
        directed("dec_wrap", "-.", 8'h00);
        directed("move", "+>-<.", 8'h00);
        check("move_cell1", int'(dmem[1]), 8'hFF);
        directed("loop", "++[>+++<-]>.", 8'h00);
        check("loop_cell0", int'(dmem[0]), 8'h00);

        ready_pct = 0;
        fork
            directed("in_stall", ",+.", 8'h41);
            begin
                for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
                repeat (3) @(negedge clk);
                ready_pct = 100;
            end
        join
        ready_pct = 100;

        directed("scan_fault", "[+", 8'h00);
        check("scan_fault_writes", wr_count, 0);
        directed("after_fault", "+.", 8'h00);

        // Reset in the middle of a forward scan.
        load_str("[++++++++++].");
        @(posedge clk); #1;
        clr_mem = 1'b1;
        @(posedge clk); #1;
        clr_mem = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midscan_busy", int'(busy), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("midscan_reset");
        directed("restart", "[++++++++++].", 8'h00);

        for (int r = 0; r < 12; r++) begin
            bit ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                gen_prog();
                ref_in.delete();
                for (int i = 0; i < 16; i++) ref_in.push_back(8'($urandom));
                ok = ref_run(1500);
            end
            if (!ok) begin
                load_str("+.");
                void'(ref_run(100));
            end
            ready_pct = $urandom_range(100, 30);
            in_pct    = $urandom_range(100, 30);
            run_current($sformatf("rand%0d", r), 20000);
        end
        ready_pct = 100;
        in_pct = 100;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
